tdm_demux8: RTL and testbench

// Receive-side counterpart of the 8:1 selection path: rebuilds 8 parallel lanes from a

---
 rtl/tdm_demux8.sv | 115 +++++++++++
 tb/tb_tdm_demux8.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// tdm_demux8: rebuilds 8 parallel lanes from a TDM sample stream.
// Locks to a frame marker on slot 0, fills a shadow frame slot by slot and
// publishes each complete 0..7 frame as one registered parallel word.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   din_i          TDM sample for the current slot (W bits)
//   din_valid_i    din_i carries a sample this cycle
//   frame_sync_i   marks din_i as slot 0 (ignored when din_valid_i=0)
//   dout_o         last complete frame, lane k = dout_o[k*W +: W]
//   dout_valid_o   one-cycle pulse when dout_o updates
//   locked_o       high while locked to the frame
//   slot_idx_o     slot the next accepted sample is written to
//   sync_err_o     one-cycle pulse on a framing violation
module tdm_demux8 #(
  parameter int unsigned W            = 1,
  parameter bit          REQUIRE_SYNC = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [W-1:0]   din_i,
  input  logic           din_valid_i,
  input  logic           frame_sync_i,
  output logic [8*W-1:0] dout_o,
  output logic           dout_valid_o,
  output logic           locked_o,
  output logic [2:0]     slot_idx_o,
  output logic           sync_err_o
);

  localparam int unsigned NLANE = 8;
  localparam int unsigned SHW   = (NLANE - 1) * W;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  // Slot 7 is never stored: it goes straight to dout together with slots 0..6.
  logic [SHW-1:0]   shadow_q, shadow_d;
  logic [8*W-1:0]   dout_q, dout_d;
  logic             dval_q, dval_d;
  logic             serr_q, serr_d;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= HUNT;
      slot_q   <= 3'd0;
      shadow_q <= '0;
      dout_q   <= '0;
      dval_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dval_q   <= dval_d;
      serr_q   <= serr_d;
    end
  end

  // Framing decisions and shadow/dout updates
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    dval_d   = 1'b0;
    serr_d   = 1'b0;

    if (din_valid_i) begin
      case (state_q)
        HUNT: begin
          if (frame_sync_i) begin
            shadow_d[W-1:0] = din_i;
            slot_d          = 3'd1;
            state_d         = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync_i && (slot_q != 3'd0)) begin
            // Resync: restart at slot 0; stale lanes are overwritten before publishing.
            serr_d          = 1'b1;
            shadow_d[W-1:0] = din_i;
            slot_d          = 3'd1;
          end else if (!frame_sync_i && (slot_q == 3'd0) && REQUIRE_SYNC) begin
            serr_d  = 1'b1;
            state_d = HUNT;
          end else begin
            for (int k = 0; k < int'(NLANE - 1); k++) begin
              if (slot_q == 3'(k)) shadow_d[k*W +: W] = din_i;
            end
            if (slot_q == 3'd7) begin
              dout_d = {din_i, shadow_q};
              dval_d = 1'b1;
            end
            slot_d = slot_q + 3'd1;
          end
        end
      endcase
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dval_q;
  assign locked_o     = (state_q == LOCKED);
  assign slot_idx_o   = slot_q;
  assign sync_err_o   = serr_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: one strict (REQUIRE_SYNC=1) and one relaxed
// (REQUIRE_SYNC=0) instance share the same stimulus and are compared every
// cycle against a slot-array reference model, plus table vectors and
// directed corner sequences.
module tb_tdm_demux8;

  localparam int unsigned W  = 4;
  localparam int unsigned DW = 8 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic [W-1:0]  din = '0;

  logic [DW-1:0] dout_s, dout_r;
  logic          dval_s, dval_r, lock_s, lock_r, serr_s, serr_r;
  logic [2:0]    slot_s, slot_r;

  always #5 clk = ~clk;

  tdm_demux8 #(.W(W), .REQUIRE_SYNC(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid),
    .frame_sync_i(frame_sync), .dout_o(dout_s), .dout_valid_o(dval_s),
    .locked_o(lock_s), .slot_idx_o(slot_s), .sync_err_o(serr_s));

  tdm_demux8 #(.W(W), .REQUIRE_SYNC(1'b0)) dut_r (
    .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid),
    .frame_sync_i(frame_sync), .dout_o(dout_r), .dout_valid_o(dval_r),
    .locked_o(lock_r), .slot_idx_o(slot_r), .sync_err_o(serr_r));

  int checks = 0;
  int errors = 0;
  int np_s = 0;
  int np_r = 0;

  // Reference model: index 0 = strict instance, index 1 = relaxed instance.
  bit            m_lock [2];
  int            m_slot [2];
  logic [W-1:0]  m_lane [2][8];
  logic [DW-1:0] m_dout [2];
  bit            m_dval [2];
  bit            m_serr [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    for (int i = 0; i < 2; i++) begin
      m_dval[i] = 1'b0;
      m_serr[i] = 1'b0;
      if (r) begin
        m_lock[i] = 1'b0;
        m_slot[i] = 0;
        m_dout[i] = '0;
        for (int k = 0; k < 8; k++) m_lane[i][k] = '0;
      end else if (v) begin
        if (!m_lock[i]) begin
          if (s) begin
            m_lane[i][0] = d;
            m_slot[i]    = 1;
            m_lock[i]    = 1'b1;
          end
        end else if (s && m_slot[i] != 0) begin
          m_serr[i]    = 1'b1;
          m_lane[i][0] = d;
          m_slot[i]    = 1;
        end else if (!s && m_slot[i] == 0 && i == 0) begin
          m_serr[i] = 1'b1;
          m_lock[i] = 1'b0;
        end else begin
          m_lane[i][m_slot[i]] = d;
          if (m_slot[i] == 7) begin
            for (int k = 0; k < 8; k++) m_dout[i][k*W +: W] = m_lane[i][k];
            m_dval[i] = 1'b1;
          end
          m_slot[i] = (m_slot[i] + 1) % 8;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
  task automatic apply(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    rst = r; din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    chk("s_dout", 64'(dout_s), 64'(m_dout[0]));
    chk("s_dval", 64'(dval_s), 64'(m_dval[0]));
    chk("s_lock", 64'(lock_s), 64'(m_lock[0]));
    chk("s_slot", 64'(slot_s), 64'(m_slot[0]));
    chk("s_serr", 64'(serr_s), 64'(m_serr[0]));
    chk("r_dout", 64'(dout_r), 64'(m_dout[1]));
    chk("r_dval", 64'(dval_r), 64'(m_dval[1]));
    chk("r_lock", 64'(lock_r), 64'(m_lock[1]));
    chk("r_slot", 64'(slot_r), 64'(m_slot[1]));
    chk("r_serr", 64'(serr_r), 64'(m_serr[1]));
    if (dval_s === 1'b1) np_s++;
    if (dval_r === 1'b1) np_r++;
  endtask

  typedef struct {
    bit          r;
    bit          v;
    bit          s;
    logic [3:0]  d;
    logic [31:0] edout;
    bit          edval;
    bit          elock;
    logic [2:0]  eslot;
    bit          eserr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Reset, three unsynced samples in HUNT, idle, then a synced frame 1..8.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h9, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hA, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hB, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'hC, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'h1, 32'h0, 1'b0, 1'b1, 3'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h2, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h3, 32'h0, 1'b0, 1'b1, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 3'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h4, 32'h0, 1'b0, 1'b1, 3'd4, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h5, 32'h0, 1'b0, 1'b1, 3'd5, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h6, 32'h0, 1'b0, 1'b1, 3'd6, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h7, 32'h0, 1'b0, 1'b1, 3'd7, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 32'h87654321, 1'b1, 1'b1, 3'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 32'h87654321, 1'b0, 1'b1, 3'd0, 1'b0});

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      chk("tbl_dout", 64'(dout_s), 64'(tbl[i].edout));
      chk("tbl_dval", 64'(dval_s), 64'(tbl[i].edval));
      chk("tbl_lock", 64'(lock_s), 64'(tbl[i].elock));
      chk("tbl_slot", 64'(slot_s), 64'(tbl[i].eslot));
      chk("tbl_serr", 64'(serr_s), 64'(tbl[i].eserr));
    end

    // Resync: frame_sync arrives on slot 5.
    np_s = 0;
    apply(1'b0, 1'b1, 1'b1, 4'h1);
    for (int k = 2; k <= 5; k++) apply(1'b0, 1'b1, 1'b0, 4'(k));
    chk("pre_resync_slot", 64'(slot_s), 64'd5);
    apply(1'b0, 1'b1, 1'b1, 4'hF);
    chk("resync_serr", 64'(serr_s), 64'd1);
    chk("resync_slot", 64'(slot_s), 64'd1);
    chk("resync_lock", 64'(lock_s), 64'd1);
    apply(1'b0, 1'b0, 1'b0, 4'h0);
    chk("resync_serr_once", 64'(serr_s), 64'd0);
    for (int k = 1; k < 8; k++) apply(1'b0, 1'b1, 1'b0, 4'(15 - k));
    chk("resync_dout", 64'(dout_s), 64'h89ABCDEF);
    chk("resync_dval", 64'(dval_s), 64'd1);
    chk("resync_pulses", 64'(np_s), 64'd1);

    // Slot-0 sample without frame_sync: strict drops lock, relaxed accepts.
    np_s = 0; np_r = 0;
    apply(1'b0, 1'b1, 1'b0, 4'h3);
    chk("nosync_s_serr", 64'(serr_s), 64'd1);
    chk("nosync_s_lock", 64'(lock_s), 64'd0);
    chk("nosync_r_serr", 64'(serr_r), 64'd0);
    chk("nosync_r_slot", 64'(slot_r), 64'd1);
    for (int k = 4; k <= 10; k++) apply(1'b0, 1'b1, 1'b0, 4'(k));
    chk("nosync_r_dval", 64'(dval_r), 64'd1);
    chk("nosync_r_dout", 64'(dout_r), 64'hA9876543);
    chk("nosync_s_dout", 64'(dout_s), 64'h89ABCDEF);
    chk("nosync_s_pulses", 64'(np_s), 64'd0);

    // Three frames with random idle gaps.
    apply(1'b1, 1'b0, 1'b0, 4'h0);
    np_s = 0; np_r = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 2)) apply(1'b0, 1'b0, 1'($urandom), 4'($urandom));
        apply(1'b0, 1'b1, (k == 0), 4'($urandom));
      end
    end
    chk("gap_pulses_s", 64'(np_s), 64'd3);
    chk("gap_pulses_r", 64'(np_r), 64'd3);

    // Random soak against the model.
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), 4'($urandom));
    end

    // Reset after slot 4 of a frame following a published frame.
    apply(1'b1, 1'b0, 1'b0, 4'h0);
    apply(1'b0, 1'b1, 1'b1, 4'h1);
    for (int k = 2; k <= 8; k++) apply(1'b0, 1'b1, 1'b0, 4'(k));
    chk("pre_rst_dout", 64'(dout_s), 64'h87654321);
    apply(1'b0, 1'b1, 1'b1, 4'hE);
    for (int k = 0; k < 4; k++) apply(1'b0, 1'b1, 1'b0, 4'hD);
    apply(1'b1, 1'b1, 1'b0, 4'hD);
    chk("rst_dout", 64'(dout_s), 64'h0);
    chk("rst_lock", 64'(lock_s), 64'd0);
    chk("rst_slot", 64'(slot_s), 64'd0);
    np_s = 0; np_r = 0;
    for (int k = 0; k < 5; k++) apply(1'b0, 1'b1, 1'b0, 4'hC);
    chk("post_rst_pulses_s", 64'(np_s), 64'd0);
    chk("post_rst_dout", 64'(dout_s), 64'h0);
    apply(1'b0, 1'b1, 1'b1, 4'h0);
    for (int k = 1; k < 8; k++) apply(1'b0, 1'b1, 1'b0, 4'(k));
    chk("post_rst_frame", 64'(dout_s), 64'h76543210);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
